// File: rtl/pump_rotator.sv
// rtl/pump_rotator.sv - N-pump lead/lag rotation controller with fault failover
// Optional start counter enabled by defining PUMP_START_COUNT_EN.
module pump_rotator #(
    parameter int N_PUMPS       = 4,
    parameter int MIN_ON_CYCLES = 16,
    parameter int CNT_W         = 8,
    localparam int IDX_W        = $clog2(N_PUMPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               demand,
    input  logic [N_PUMPS-1:0] pump_fault,
    output logic [N_PUMPS-1:0] pump_en,
    output logic [IDX_W-1:0]   active_idx,
    output logic               running,
    output logic               failover,
    output logic               all_faulted,
    output logic [15:0]        start_count
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PUMPS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   active_idx_q, active_idx_d;
    logic [N_PUMPS-1:0] pump_en_q, pump_en_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic               failover_q, failover_d;
    logic               all_faulted_q;

    logic [IDX_W-1:0]   sel_idx, cand;
    logic               sel_valid;

    // Walk candidates from farthest to nearest so the nearest healthy pump after active_idx wins;
    // active_idx itself (k = N_PUMPS) is the last resort.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = active_idx_q;
        cand      = active_idx_q;
        for (int k = N_PUMPS; k >= 1; k--) begin
            cand = IDX_W'((int'(active_idx_q) + k) % N_PUMPS);
            if (!pump_fault[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        active_idx_d = active_idx_q;
        pump_en_d    = pump_en_q;
        run_cnt_d    = run_cnt_q;
        failover_d   = 1'b0;
        case (state_q)
            IDLE: begin
                pump_en_d = '0;
                if (demand && sel_valid) begin
                    state_d            = RUN;
                    active_idx_d       = sel_idx;
                    pump_en_d[sel_idx] = 1'b1;
                    run_cnt_d          = '0;
                end
            end
            RUN: begin
                // A fault on the running pump outranks both demand drop and the minimum-run exit.
                if (pump_fault[active_idx_q]) begin
                    pump_en_d = '0;
                    if (sel_valid) begin
                        active_idx_d       = sel_idx;
                        pump_en_d[sel_idx] = 1'b1;
                        run_cnt_d          = '0;
                        failover_d         = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (run_cnt_q == CNT_MAX && !demand) begin
                    state_d   = IDLE;
                    pump_en_d = '0;
                end else if (run_cnt_q != CNT_MAX) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            active_idx_q  <= IDX_LAST;
            pump_en_q     <= '0;
            run_cnt_q     <= '0;
            failover_q    <= 1'b0;
            all_faulted_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_idx_q  <= active_idx_d;
            pump_en_q     <= pump_en_d;
            run_cnt_q     <= run_cnt_d;
            failover_q    <= failover_d;
            all_faulted_q <= &pump_fault;
        end
    end

`ifdef PUMP_START_COUNT_EN
    logic [15:0] start_count_q;
    logic        start_inc;

    assign start_inc = (state_q == IDLE && state_d == RUN) || failover_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_count_q <= 16'h0000;
        end else if (start_inc && start_count_q != 16'hFFFF) begin
            start_count_q <= start_count_q + 16'h0001;
        end
    end

    assign start_count = start_count_q;
`else
    assign start_count = 16'h0000;
`endif

    assign pump_en     = pump_en_q;
    assign active_idx  = active_idx_q;
    assign running     = (state_q == RUN);
    assign failover    = failover_q;
    assign all_faulted = all_faulted_q;

endmodule

// File: tb/tb_pump_rotator.sv
// tb/tb_pump_rotator.sv - randomized and directed checks of pump_rotator against a behavioural model
module tb_pump_rotator;

    localparam int N   = 4;
    localparam int MIN = 16;
    localparam int IW  = $clog2(N);

    logic          clk;
    logic          reset;
    logic          demand;
    logic [N-1:0]  pump_fault;
    logic [N-1:0]  pump_en;
    logic [IW-1:0] active_idx;
    logic          running;
    logic          failover;
    logic          all_faulted;
    logic [15:0]   start_count;

    int checks = 0;
    int errors = 0;

    // Model: pump on/off, which pump, guaranteed edges left before a stop is allowed.
    bit m_on;
    int m_idx;
    int m_left;
    bit m_fo;
    bit m_all;
    int m_starts;

    pump_rotator #(.N_PUMPS(N), .MIN_ON_CYCLES(MIN), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .demand      (demand),
        .pump_fault  (pump_fault),
        .pump_en     (pump_en),
        .active_idx  (active_idx),
        .running     (running),
        .failover    (failover),
        .all_faulted (all_faulted),
        .start_count (start_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_healthy(int i, logic [N-1:0] f);
        for (int k = 1; k <= N; k++) begin
            if (!f[(i + k) % N]) return (i + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_on = 0; m_idx = N - 1; m_left = 0; m_fo = 0; m_all = 0; m_starts = 0;
    endtask

    task automatic model_edge();
        int n;
        n     = next_healthy(m_idx, pump_fault);
        m_fo  = 0;
        m_all = &pump_fault;
        if (!m_on) begin
            if (demand && n >= 0) begin
                m_on = 1; m_idx = n; m_left = MIN - 1; m_starts++;
            end
        end else if (pump_fault[m_idx]) begin
            if (n >= 0) begin
                m_idx = n; m_left = MIN - 1; m_fo = 1; m_starts++;
            end else begin
                m_on = 0;
            end
        end else if (m_left == 0 && !demand) begin
            m_on = 0;
        end else if (m_left > 0) begin
            m_left--;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] exp_en;
        int exp_sc;
        exp_en = m_on ? (N'(1) << m_idx) : '0;
`ifdef PUMP_START_COUNT_EN
        exp_sc = (m_starts > 65535) ? 65535 : m_starts;
`else
        exp_sc = 0;
`endif
        check("pump_en", 32'(pump_en), 32'(exp_en));
        check("active_idx", 32'(active_idx), 32'(m_idx));
        check("running", 32'(running), 32'(m_on));
        check("failover", 32'(failover), 32'(m_fo));
        check("all_faulted", 32'(all_faulted), 32'(m_all));
        check("start_count", 32'(start_count), 32'(exp_sc));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_and_wait(input int gap);
        demand = 1'b1;
        step();
        demand = 1'b0;
        steps(gap - 1);
    endtask

    initial begin
        int en_cycles;
        reset      = 1'b0;
        demand     = 1'b0;
        pump_fault = '0;
        model_reset();
        #12;
        check("reset_pump_en", 32'(pump_en), 32'h0);
        check("reset_active_idx", 32'(active_idx), 32'(N - 1));
        compare_all();
        reset = 1'b1;

        // Four pulses rotate through the pumps; each runs exactly MIN cycles.
        for (int p = 0; p < N; p++) begin
            demand = 1'b1;
            step();
            demand = 1'b0;
            check("rotate_order", 32'(active_idx), 32'(p));
            en_cycles = 1;
            for (int c = 0; c < 39; c++) begin
                step();
                if (pump_en != '0) en_cycles++;
            end
            check("min_on_len", 32'(en_cycles), 32'(MIN));
        end

        // Skip a faulted pump; lone healthy pump restarts itself.
        pulse_and_wait(40);
        pump_fault = 4'b0010;
        pulse_and_wait(1);
        check("skip_faulted", 32'(active_idx), 32'd2);
        steps(39);
        pump_fault = 4'b1110;
        pulse_and_wait(40);
        pulse_and_wait(1);
        check("self_restart", 32'(active_idx), 32'd0);
        steps(39);

        // Failover from pump 1 at run_cnt 5 under demand.
        pump_fault = '0;
        demand = 1'b1;
        step();
        steps(5);
        pump_fault = 4'b0010;
        step();
        check("failover_en", 32'(pump_en), 32'h4);
        check("failover_pulse", 32'(failover), 32'd1);
        demand = 1'b0;
        step();
        check("failover_clear", 32'(failover), 32'd0);
        steps(40);

        // All faulted blocks starts; clearing pump 3 starts it next edge.
        pump_fault = 4'b1111;
        demand = 1'b1;
        steps(3);
        check("allf_running", 32'(running), 32'd0);
        check("allf_flag", 32'(all_faulted), 32'd1);
        pump_fault = 4'b0111;
        step();
        check("allf_recover", 32'(pump_en), 32'h8);
        pump_fault = '0;

        // Long demand holds one pump; then reset mid-run drops enables at once.
        steps(100);
        demand = 1'b0;
        steps(3);
        check("hold_release", 32'(pump_en), 32'h0);
        demand = 1'b1;
        steps(4);
        demand = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_rst_en", 32'(pump_en), 32'h0);
        check("async_rst_idx", 32'(active_idx), 32'd3);
        #1;
        reset = 1'b1;

        // Randomized demand and fault patterns.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) < 3) demand = ~demand;
            if ($urandom_range(0, 24) == 0) pump_fault[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0) pump_fault = '1;
            if ($urandom_range(0, 199) == 0) pump_fault = '0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
